// File: rtl/riscv_test_harness_ctrl.sv
// Run controller for RISC-V core bring-up: sequences core reset, counts run cycles, snoops tohost stores.
// Optional PC-stall watchdog (pc port, stall output) is built when RISCV_HARNESS_STALL_EN is defined.
module riscv_test_harness_ctrl #(
  parameter int unsigned            ADDR_W         = 32,
  parameter int unsigned            DATA_W         = 32,
  parameter logic [ADDR_W-1:0]      TOHOST_ADDR    = 32'h0000_1000,
  parameter int unsigned            RST_CYCLES     = 2,
  parameter int unsigned            TIMEOUT_CYCLES = 1000,
  parameter int unsigned            CNT_W          = 32,
  parameter int unsigned            STALL_CYCLES   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              core_rst,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
`ifdef RISCV_HARNESS_STALL_EN
  input  logic [ADDR_W-1:0] pc,
  output logic              stall,
`endif
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [DATA_W-1:0] fail_code,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_RUN, S_PASS, S_FAIL, S_TIMEOUT, S_STALL
  } state_t;

  localparam int unsigned RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LAST     = RST_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             state;
  logic [RST_W-1:0]   rst_cnt;
  logic               hit, hit_pass, hit_fail, timeout_hit, stall_hit;
  logic [CNT_W-1:0]   cnt_next;

  assign hit         = mem_we && (mem_addr == TOHOST_ADDR);
  assign hit_pass    = hit && (mem_wdata == DATA_W'(1));
  assign hit_fail    = hit && mem_wdata[0] && !hit_pass;
  assign timeout_hit = (cycle_count == TIMEOUT_LAST);
  assign cnt_next    = (&cycle_count) ? cycle_count : cycle_count + 1'b1;

`ifdef RISCV_HARNESS_STALL_EN
  localparam int unsigned STALL_W = $clog2(STALL_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES);

  logic [STALL_W-1:0] stall_cnt, stall_cnt_next;
  logic [ADDR_W-1:0]  prev_pc;

  // Count consecutive edges on which the PC did not move.
  assign stall_cnt_next = (pc == prev_pc) ? stall_cnt + 1'b1 : '0;
  assign stall_hit      = (stall_cnt_next == STALL_LAST);
`else
  assign stall_hit = 1'b0;
`endif

  // NOTE: all state and outputs update with non-blocking assignments so every
  // branch below reads the pre-edge values, keeping the registers race-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      rst_cnt     <= '0;
      core_rst    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      fail_code   <= '0;
      cycle_count <= '0;
`ifdef RISCV_HARNESS_STALL_EN
      stall       <= 1'b0;
      stall_cnt   <= '0;
      prev_pc     <= '0;
`endif
    end else begin
      case (state)
        S_RESET: begin
          if (rst_cnt == RST_LAST) begin
            state    <= S_RUN;
            core_rst <= 1'b0;
`ifdef RISCV_HARNESS_STALL_EN
            stall_cnt <= '0;
            prev_pc   <= pc;
`endif
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end

        S_RUN: begin
          cycle_count <= cnt_next;
`ifdef RISCV_HARNESS_STALL_EN
          stall_cnt <= stall_cnt_next;
          prev_pc   <= pc;
`endif
          if (hit_pass || hit_fail || stall_hit || timeout_hit) begin
            core_rst <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
          // Priority: tohost hit, then stall, then timeout.
          if (hit_pass) begin
            state <= S_PASS;
            pass  <= 1'b1;
          end else if (hit_fail) begin
            state     <= S_FAIL;
            fail_code <= mem_wdata >> 1;
          end else if (stall_hit) begin
            state <= S_STALL;
`ifdef RISCV_HARNESS_STALL_EN
            stall <= 1'b1;
`endif
          end else if (timeout_hit) begin
            state   <= S_TIMEOUT;
            timeout <= 1'b1;
          end
        end

        // IDLE and every terminal state restart the same way on start.
        default: begin
          if (start) begin
            state       <= S_RESET;
            rst_cnt     <= '0;
            core_rst    <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            fail_code   <= '0;
            cycle_count <= '0;
`ifdef RISCV_HARNESS_STALL_EN
            stall       <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_test_harness_ctrl.sv
// Directed bench for riscv_test_harness_ctrl (RST_CYCLES=2, TIMEOUT_CYCLES=50, STALL_CYCLES=8).
// Stall scenarios run only when RISCV_HARNESS_STALL_EN is defined.
module tb_riscv_test_harness_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        core_rst;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] pc = 32'h0;
  logic        pc_hold = 1'b0;
  logic        stall;
  logic        busy, done, pass, timeout;
  logic [31:0] fail_code;
  logic [31:0] cycle_count;

  int n_cmp = 0;
  int n_bad = 0;

  riscv_test_harness_ctrl #(
    .RST_CYCLES(2), .TIMEOUT_CYCLES(50), .STALL_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .core_rst(core_rst),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef RISCV_HARNESS_STALL_EN
    .pc(pc), .stall(stall),
`endif
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .fail_code(fail_code), .cycle_count(cycle_count)
  );

`ifndef RISCV_HARNESS_STALL_EN
  assign stall = 1'b0;
`endif

  always #5 clk = ~clk;

  // One clock edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (!pc_hold) pc = pc + 32'd4;
    end
  endtask

  // Pulse start and walk through RESET; returns at RUN with cycle_count=0.
  task automatic start_run();
    start = 1'b1; step(); start = 1'b0; step(2);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    mem_we = 1'b1; mem_addr = addr; mem_wdata = data;
    step();
    mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); rst = 1'b0;
    n_cmp++; if ({core_rst, busy, done, pass, timeout, stall} !== 6'b100000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 100000", {core_rst, busy, done, pass, timeout, stall}); end
    n_cmp++; if (fail_code !== 32'd0 || cycle_count !== 32'd0) begin
      n_bad++; $display("FAIL reset_values: fail_code=%0h cycle_count=%0d want 0/0", fail_code, cycle_count); end
    step();
    start = 1'b1; step();
    n_cmp++; if (core_rst !== 1'b1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL reset_phase1: core_rst=%b busy=%b want 1/1", core_rst, busy); end
    step(); start = 1'b0;  // start held during RESET must be ignored
    n_cmp++; if (core_rst !== 1'b1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL reset_phase2: core_rst=%b busy=%b want 1/1", core_rst, busy); end
    step();
    n_cmp++; if (core_rst !== 1'b0 || busy !== 1'b1 || cycle_count !== 32'd0) begin
      n_bad++; $display("FAIL run_entry: core_rst=%b busy=%b cnt=%0d want 0/1/0", core_rst, busy, cycle_count); end
  endtask

  task automatic test_pass();
    step(9);
    start = 1'b1; step(); start = 1'b0;  // ignored in RUN
    n_cmp++; if (cycle_count !== 32'd10 || busy !== 1'b1 || core_rst !== 1'b0) begin
      n_bad++; $display("FAIL start_in_run: cnt=%0d busy=%b core_rst=%b want 10/1/0", cycle_count, busy, core_rst); end
    step(9);
    store(32'h1000, 32'd1);
    n_cmp++; if ({pass, done, busy, core_rst, timeout} !== 5'b11010 || cycle_count !== 32'd20) begin
      n_bad++; $display("FAIL pass_at_20: flags=%b cnt=%0d want 11010/20", {pass, done, busy, core_rst, timeout}, cycle_count); end
    step(3);
    n_cmp++; if (pass !== 1'b1 || cycle_count !== 32'd20) begin
      n_bad++; $display("FAIL pass_held: pass=%b cnt=%0d want 1/20", pass, cycle_count); end
  endtask

  task automatic test_restart_fail();
    start = 1'b1; step(); start = 1'b0;
    n_cmp++; if ({pass, done, busy, core_rst} !== 4'b0011) begin
      n_bad++; $display("FAIL restart: flags=%b want 0011", {pass, done, busy, core_rst}); end
    step(2);
    step(3);
    store(32'h1000, 32'h4);        // even value: not a tohost verdict
    store(32'h1004, 32'h1);        // other address
    mem_addr = 32'h1000; mem_wdata = 32'h1; step(); mem_addr = '0; mem_wdata = '0;  // no write enable
    n_cmp++; if (done !== 1'b0 || busy !== 1'b1 || cycle_count !== 32'd6) begin
      n_bad++; $display("FAIL ignored_stores: done=%b busy=%b cnt=%0d want 0/1/6", done, busy, cycle_count); end
    store(32'h1000, 32'h7);
    n_cmp++; if ({done, pass, core_rst} !== 3'b101 || fail_code !== 32'd3 || cycle_count !== 32'd7) begin
      n_bad++; $display("FAIL fail_code: flags=%b code=%0d cnt=%0d want 101/3/7", {done, pass, core_rst}, fail_code, cycle_count); end
  endtask

  task automatic test_timeout();
    start_run();
    step(49);
    n_cmp++; if (timeout !== 1'b0 || busy !== 1'b1 || fail_code !== 32'd0) begin
      n_bad++; $display("FAIL pre_timeout: timeout=%b busy=%b code=%0d want 0/1/0", timeout, busy, fail_code); end
    step();
    n_cmp++; if ({timeout, done, pass, core_rst} !== 4'b1101 || cycle_count !== 32'd50) begin
      n_bad++; $display("FAIL timeout_50: flags=%b cnt=%0d want 1101/50", {timeout, done, pass, core_rst}, cycle_count); end
    start_run();
    step(49);
    store(32'h1000, 32'd1);        // same edge as timeout: hit wins
    n_cmp++; if (pass !== 1'b1 || timeout !== 1'b0 || cycle_count !== 32'd50) begin
      n_bad++; $display("FAIL hit_beats_timeout: pass=%b timeout=%b cnt=%0d want 1/0/50", pass, timeout, cycle_count); end
  endtask

  task automatic test_rst_mid_run();
    start_run();
    step(5);
    rst = 1'b1; step(); rst = 1'b0;
    n_cmp++; if ({core_rst, busy, done, pass, timeout, stall} !== 6'b100000 || cycle_count !== 32'd0) begin
      n_bad++; $display("FAIL rst_mid_run: flags=%b cnt=%0d want 100000/0", {core_rst, busy, done, pass, timeout, stall}, cycle_count); end
    step(3);
    n_cmp++; if (busy !== 1'b0 || core_rst !== 1'b1) begin
      n_bad++; $display("FAIL idle_hold: busy=%b core_rst=%b want 0/1", busy, core_rst); end
  endtask

`ifdef RISCV_HARNESS_STALL_EN
  task automatic test_stall();
    pc_hold = 1'b1; pc = 32'h40;
    start_run();
    step(7);
    n_cmp++; if (stall !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL stall_7: stall=%b busy=%b want 0/1", stall, busy); end
    step();
    n_cmp++; if ({stall, done, pass, core_rst} !== 4'b1101 || cycle_count !== 32'd8) begin
      n_bad++; $display("FAIL stall_8: flags=%b cnt=%0d want 1101/8", {stall, done, pass, core_rst}, cycle_count); end
    start_run();
    step(6);
    pc = 32'h44; step();
    step(7);
    n_cmp++; if (stall !== 1'b0 || busy !== 1'b1 || cycle_count !== 32'd14) begin
      n_bad++; $display("FAIL stall_broken: stall=%b busy=%b cnt=%0d want 0/1/14", stall, busy, cycle_count); end
    pc_hold = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_pass();
    test_restart_fail();
    test_timeout();
    test_rst_mid_run();
`ifdef RISCV_HARNESS_STALL_EN
    test_stall();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
